// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    // Operand source selected for the E-stage ALU inputs.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Data-memory handshake states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // The PC register is never forwarded; its value comes from the PC path.
    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forwarding compare for one E-stage source operand (M result wins over W).
module fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [3:0] src,
    input  logic [3:0] dst_m,
    input  logic [3:0] dst_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   sel
);

    // Pick the youngest in-flight producer of the source register.
    always_comb begin
        sel = FWD_RF;
        if (src != REG_PC) begin
            if (reg_write_m && (dst_m == src)) begin
                sel = FWD_M;
            end else if (reg_write_w && (dst_w == src)) begin
                sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline:
// operand forwarding, load-use / PC / branch stalls and flushes, and a
// handshake FSM that freezes the pipeline during multi-cycle memory access.
// Optional macro STALL_PERF_CNT_EN adds stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       BranchTakenE,
    input  logic       MemReqM,
    input  logic       mem_ack,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       mem_req,
    output logic       mem_timeout_err
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    fwd_sel_t   fwd_a;
    fwd_sel_t   fwd_b;
    mem_state_t state;
    mem_state_t state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic       timeout;
    logic       wait_stall;
    logic       mem_stall;
    logic       ld_stall;
    logic       pc_pend;

    fwd_unit u_fwd_a (
        .src         (RA1E),
        .dst_m       (WA3M),
        .dst_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .src         (RA2E),
        .dst_m       (WA3M),
        .dst_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    // Memory handshake next state, wait counter and raw stall request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        timeout    = 1'b0;
        wait_stall = 1'b0;
        case (state)
            IDLE: begin
                if (MemReqM && !mem_ack) begin
                    wait_stall = 1'b1;
                    state_next = WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    wait_stall = 1'b1;
                    cnt_next   = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Qualifying with reset makes an aborted access drop its request and stall at once.
    assign mem_stall = wait_stall & rst;
    assign mem_req   = MemReqM & rst;

    // Stall/flush enables; memory freeze overrides the pipeline hazards.
    always_comb begin
        ld_stall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
        pc_pend  = PCSrcD || PCSrcE || PCSrcM;
        StallF   = ld_stall || pc_pend;
        StallD   = ld_stall;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = pc_pend || BranchTakenE;
        FlushE   = ld_stall || BranchTakenE;
        FlushW   = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    // FSM state and wait counter, updated with the segment registers on the falling edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            mem_timeout_err <= 1'b0;
        end else if (timeout) begin
            mem_timeout_err <= 1'b1;
        end
    end

`ifdef STALL_PERF_CNT_EN
    // Saturating counts of fetch-stall cycles and E-flush cycles.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (StallF && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (FlushE && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule
